// File: rtl/kamacore_muldiv_ctrl.sv
// rtl/kamacore_muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer
// Radix-2 shift-add multiply and restoring divide, one bit per RUN cycle.
module kamacore_muldiv_ctrl #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_funct3,
    input  logic [CPU_WIDTH-1:0] req_rs1,
    input  logic [CPU_WIDTH-1:0] req_rs2,
    output logic                 resp_valid,
    output logic [CPU_WIDTH-1:0] resp_result,
    output logic                 stall_ex
);
    localparam int W  = CPU_WIDTH;
    localparam int CW = $clog2(CPU_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       f3_q;
    logic             neg_q;
    logic             neg_r;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     opb;

    // Operand decode at accept
    logic         rs1_signed, rs2_signed, sa, sb;
    logic [W-1:0] mag_a, mag_b;
    logic         div_zero, div_ovf;
    logic [W-1:0] special_result;

    always_comb begin
        rs1_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                     (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
        rs2_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
                     (req_funct3 == 3'b110);
        sa         = rs1_signed && req_rs1[W-1];
        sb         = rs2_signed && req_rs2[W-1];
        mag_a      = sa ? -req_rs1 : req_rs1;
        mag_b      = sb ? -req_rs2 : req_rs2;
        div_zero   = req_funct3[2] && (req_rs2 == '0);
        div_ovf    = req_funct3[2] && !req_funct3[0] &&
                     (req_rs1 == MIN_NEG) && (req_rs2 == '1);
        if (div_zero)
            special_result = req_funct3[1] ? req_rs1 : '1;
        else
            special_result = req_funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration: prod holds {partial, multiplier} or {remainder, dividend/quotient}
    logic [W-1:0]   mul_add;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] iter_next;
    logic [2*W-1:0] mul_fix;
    logic [W-1:0]   mul_res, div_q, div_r, div_res, fix_result;

    always_comb begin
        mul_add    = prod[0] ? opb : '0;
        mul_sum    = {1'b0, prod[2*W-1:W]} + {1'b0, mul_add};
        mul_next   = {mul_sum, prod[W-1:1]};
        div_shift  = {prod[2*W-1:W], prod[W-1]};
        div_ge     = div_shift >= {1'b0, opb};
        div_diff   = div_shift[W-1:0] - opb;
        div_next   = {(div_ge ? div_diff : div_shift[W-1:0]), prod[W-2:0], div_ge};
        iter_next  = f3_q[2] ? div_next : mul_next;
        mul_fix    = neg_q ? -mul_next : mul_next;
        mul_res    = (f3_q[1:0] == 2'b00) ? mul_fix[W-1:0] : mul_fix[2*W-1:W];
        div_q      = neg_q ? -div_next[W-1:0] : div_next[W-1:0];
        div_r      = neg_r ? -div_next[2*W-1:W] : div_next[2*W-1:W];
        div_res    = f3_q[1] ? div_r : div_q;
        fix_result = f3_q[2] ? div_res : mul_res;
    end

    assign req_ready = (state == IDLE);
    assign stall_ex  = ((state == IDLE) && req_valid) || (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            prod        <= '0;
            opb         <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            f3_q  <= req_funct3;
                            neg_q <= sa ^ sb;
                            neg_r <= sa;
                            if (div_zero || div_ovf) begin
                                resp_result <= special_result;
                                resp_valid  <= 1'b1;
                                state       <= DONE;
                            end else begin
                                // Divide shifts the dividend out; multiply shifts the multiplier out
                                prod  <= {{W{1'b0}}, (req_funct3[2] ? mag_a : mag_b)};
                                opb   <= req_funct3[2] ? mag_b : mag_a;
                                cnt   <= CW'(CPU_WIDTH - 1);
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        prod <= iter_next;
                        if (cnt == '0) begin
                            resp_result <= fix_result;
                            resp_valid  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_kamacore_muldiv_ctrl.sv
// tb/tb_kamacore_muldiv_ctrl.sv - scoreboard bench for kamacore_muldiv_ctrl
module tb_kamacore_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic        stall_ex;

    kamacore_muldiv_ctrl #(.CPU_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_result(resp_result), .stall_ex(stall_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          pres;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_run = 0;

    localparam logic [31:0] MINV = 32'h8000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa64, sb64, ua64, ub64, p;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        case (f3)
            3'd0: begin p = ua64 * ub64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: pops the scoreboard on every response pulse
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got pulse with result %h expected no pulse", resp_result);
            end else begin
                e = sb.pop_front();
                chk("result", resp_result, e.res);
                chk("latency", 32'(cyc - e.pres), 32'(e.lat));
                chk("stall_len", 32'(stall_run), 32'(e.lat));
            end
        end
        if (!rst || flush || !stall_ex) stall_run = 0;
        else stall_run++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit expect_resp);
        int guard;
        exp_t n;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_valid  = 1'b1;
        guard = 0;
        while (!req_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
            req_valid = 1'b0;
            return;
        end
        if (expect_resp) begin
            n.res  = exp;
            n.pres = cyc;
            n.lat  = is_special(f3, a, b) ? 1 : 33;
            sb.push_back(n);
        end
        step();
        req_valid = 1'b0;
        req_rs1   = $urandom;
        req_rs2   = $urandom;
    endtask

    task automatic issue_rand(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b, model(f3, a, b), 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: begin
                case ($urandom_range(0, 3))
                    0:       return 32'h0;
                    1:       return MINV;
                    2:       return 32'hFFFF_FFFF;
                    default: return 32'h7FFF_FFFF;
                endcase
            end
        endcase
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !req_ready) && guard < 500) begin
            step();
            guard++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_rs1    = 32'h0;
        req_rs2    = 32'h0;
        step();
        step();
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_stall_ex", {31'b0, stall_ex}, 32'd0);
        rst = 1'b1;
        step();

        issue(3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 1'b1);
        issue(3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b1);
        issue(3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 1'b1);
        issue(3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b1);

        issue(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1'b1);
        issue(3'd5, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 1'b1);
        issue(3'd7, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 1'b1);

        issue(3'd4, 32'h5, 32'h0, 32'hFFFF_FFFF, 1'b1);
        issue(3'd6, 32'h5, 32'h0, 32'h0000_0005, 1'b1);
        issue(3'd5, 32'h5, 32'h0, 32'hFFFF_FFFF, 1'b1);
        issue(3'd7, 32'h5, 32'h0, 32'h0000_0005, 1'b1);
        issue(3'd4, MINV, 32'hFFFF_FFFF, MINV, 1'b1);
        issue(3'd6, MINV, 32'hFFFF_FFFF, 32'h0, 1'b1);
        drain();

        // Flush around iteration 10, then an immediate DIVU
        issue(3'd0, $urandom, $urandom, 32'h0, 1'b0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", {31'b0, req_ready}, 32'd1);
        chk("flush_no_pulse", {31'b0, resp_valid}, 32'd0);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
        drain();

        // Flush wins over a simultaneous accept
        req_funct3 = 3'd0;
        req_valid  = 1'b1;
        flush      = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_prio_ready", {31'b0, req_ready}, 32'd1);
        step();

        // Back-to-back with req_valid held
        issue_rand(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
        issue_rand(3'd0, 32'hDEAD_BEEF, 32'h0000_0013);
        drain();

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue_rand(f3, a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) step();
        end
        drain();

        // Reset abort mid-RUN
        issue(3'd1, $urandom, $urandom, 32'h0, 1'b0);
        repeat (8) step();
        rst = 1'b0;
        step();
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_resp_result", resp_result, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_stall_ex", {31'b0, stall_ex}, 32'd0);
        rst = 1'b1;
        repeat (40) step();
        chk("final_queue", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
